// File: rtl/uart_pkg.sv
// Shared UART timing and FSM state encoding, used by both the transmitter and uart_rx.
package uart_pkg;

    localparam int CLKS_PER_BIT = 234;  // 27 MHz / 115200 baud

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input pin.
// The reset value is chosen per pin so that reset release does not look like an edge.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised rx, mid-bit sampling, one-cycle valid / frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_in,
    output logic       valid,
    output logic       frame_err,
    output logic [1:0] rx_state
);

    localparam int         HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_CNT = 8'(HALF_BIT);

    uart_state_t state, state_nxt;
    logic [7:0]  clk_count;
    logic [2:0]  bit_index;
    logic [7:0]  shift;
    logic        rx_s;
    logic        frame_ok, frame_bad;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            // A start bit that is high again at its mid-point was a glitch.
            START: if (clk_count == HALF_CNT) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (clk_count == LAST_CNT && bit_index == 3'd7) state_nxt = STOP;
            STOP:  if (clk_count == LAST_CNT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Leaving at mid-stop-bit leaves half a bit of slack to catch a back-to-back start.
    always_comb begin
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (state == STOP && clk_count == LAST_CNT) begin
            frame_ok  = rx_s;
            frame_bad = !rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_count <= 8'd0;
            bit_index <= 3'd0;
            shift     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    clk_count <= 8'd0;
                    bit_index <= 3'd0;
                end
                START: clk_count <= (clk_count == HALF_CNT) ? 8'd0 : clk_count + 8'd1;
                DATA: begin
                    if (clk_count == LAST_CNT) begin
                        clk_count        <= 8'd0;
                        shift[bit_index] <= rx_s;
                        bit_index        <= bit_index + 3'd1;  // 7 wraps to 0 on entry to STOP
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end
                STOP: clk_count <= (clk_count == LAST_CNT) ? 8'd0 : clk_count + 8'd1;
                default: begin
                    clk_count <= 8'd0;
                    bit_index <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_in   <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= frame_ok;
            frame_err <= frame_bad;
            if (frame_ok) data_in <= shift;
        end
    end

    assign rx_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven serially, expected strobes are queued
// as each frame is sent and checked by a monitor when valid/frame_err fire.
module tb_uart_rx;

    localparam int CPB  = 32;
    localparam int HALF = (CPB - 1) / 2;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_in;
    logic       valid;
    logic       frame_err;
    logic [1:0] rx_state;

    int   total = 0;
    int   bad   = 0;
    int   n_valid = 0;
    int   exp_valid = 0;
    bit   prev_strobe = 1'b0;
    exp_t sb[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_in   (data_in),
        .valid     (valid),
        .frame_err (frame_err),
        .rx_state  (rx_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input bit is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        sb.push_back(e);
        if (!is_err) exp_valid++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_bit);
        rx = 1'b0;
        repeat (cpb) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cpb) @(posedge clk);
        end
        rx = stop_bit;
        repeat (cpb) @(posedge clk);
        rx = 1'b1;
    endtask

    // Strobe monitor: every pulse must match the head of the scoreboard and last one cycle.
    always @(negedge clk) begin
        if (prev_strobe) begin
            total++;
            assert (valid === 1'b0 && frame_err === 1'b0) else begin
                bad++;
                $error("FAIL strobe_width observed=%b%b expected=00", valid, frame_err);
            end
        end
        if (valid === 1'b1 || frame_err === 1'b1) begin
            exp_t e;
            total++;
            assert (!(valid && frame_err)) else begin
                bad++;
                $error("FAIL strobe_both observed=11 expected=one-hot");
            end
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_strobe observed valid=%b ferr=%b data=%h expected=none",
                       valid, frame_err, data_in);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                assert (frame_err === e.is_err && valid === !e.is_err) else begin
                    bad++;
                    $error("FAIL strobe_kind observed ferr=%b expected ferr=%b", frame_err, e.is_err);
                end
                total++;
                assert (data_in === e.data) else begin
                    bad++;
                    $error("FAIL strobe_data observed=%h expected=%h", data_in, e.data);
                end
            end
            if (valid === 1'b1) n_valid++;
            prev_strobe = 1'b1;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    initial begin
        logic [7:0] b;
        int         cpb;

        // Reset values
        repeat (5) @(posedge clk);
        #1;
        check("rst_data", data_in, 8'h00);
        check("rst_valid", {7'd0, valid}, 8'h00);
        check("rst_ferr", {7'd0, frame_err}, 8'h00);
        check("rst_state", {6'd0, rx_state}, 8'h00);
        @(posedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        check("idle_after_rst", {6'd0, rx_state}, 8'h00);

        // Single byte
        push(1'b0, 8'h55);
        send_byte(8'h55, CPB, 1'b1);
        repeat (2 * CPB) @(posedge clk);
        check("t1_drained", 8'(sb.size()), 8'h00);

        // Back-to-back, no idle gap
        push(1'b0, 8'h00); push(1'b0, 8'hFF); push(1'b0, 8'hA5);
        send_byte(8'h00, CPB, 1'b1);
        send_byte(8'hFF, CPB, 1'b1);
        send_byte(8'hA5, CPB, 1'b1);
        repeat (2 * CPB) @(posedge clk);
        check("t2_drained", 8'(sb.size()), 8'h00);

        // Stop bit low: frame_err only, data_in holds, next byte still good
        push(1'b1, 8'hA5);
        send_byte(8'h3C, CPB, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("t3_hold", data_in, 8'hA5);
        push(1'b0, 8'h81);
        send_byte(8'h81, CPB, 1'b1);
        repeat (2 * CPB) @(posedge clk);
        check("t3_drained", 8'(sb.size()), 8'h00);

        // Short low glitch, shorter than half a bit
        rx = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t4_in_start", {6'd0, rx_state}, 8'h01);
        @(posedge clk);
        rx = 1'b1;
        repeat (HALF + 10) @(posedge clk);
        #1;
        check("t4_back_idle", {6'd0, rx_state}, 8'h00);
        repeat (CPB) @(posedge clk);

        // Baud skew about +/-3%
        for (int i = 0; i < 100; i++) begin
            b   = 8'($urandom_range(0, 255));
            cpb = ($urandom_range(0, 1) != 0) ? CPB + 1 : CPB - 1;
            push(1'b0, b);
            send_byte(b, cpb, 1'b1);
        end
        repeat (2 * CPB) @(posedge clk);
        check("t5_drained", 8'(sb.size()), 8'h00);

        // Reset during bit 4 of 0xC3
        b  = 8'hC3;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        check("t6_mid_frame", {6'd0, rx_state}, 8'h02);
        rst = 1'b1;
        #1;
        check("t6_rst_state", {6'd0, rx_state}, 8'h00);
        check("t6_rst_data", data_in, 8'h00);
        check("t6_rst_strobes", {6'd0, valid, frame_err}, 8'h00);
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("t6_idle_no_strobe", {6'd0, rx_state}, 8'h00);
        push(1'b0, 8'h5A);
        send_byte(8'h5A, CPB, 1'b1);
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("t6_drained", 8'(sb.size()), 8'h00);
        check("t6_data", data_in, 8'h5A);
        check("valid_count", 8'(n_valid), 8'(exp_valid));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
